// File: rtl/bcd_countdown_timer_if.sv
// Bus bundle for the BCD round timer: control inputs, status flags and the
// four active-low seven-segment digits.
interface bcd_countdown_timer_if;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic        gameTick;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        timeUp;
  logic        warning;
  logic        load_error;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;

  // Game control side: drives commands, observes count and flags.
  modport master (
    output load, load_value, start, pause, gameTick,
    input  digits, running, expired, timeUp, warning, load_error,
    input  HEX0, HEX1, HEX2, HEX3
  );

  // Timer side.
  modport slave (
    input  load, load_value, start, pause, gameTick,
    output digits, running, expired, timeUp, warning, load_error,
    output HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// 4-digit loadable BCD round timer. Counts down once per gameTick while
// running, stops at 0000 with a one-cycle expired pulse, and drives four
// active-low seven-segment digits with optional leading-zero blanking.
module bcd_countdown_timer #(
  parameter logic [15:0] START_VALUE    = 16'h0060,
  parameter logic [15:0] WARN_THRESHOLD = 16'h0010,
  parameter bit          BLANK_LZ       = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  bcd_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        timeup_q, timeup_d;
  logic        warning_q, warning_d;
  logic        load_error_q, load_error_d;

  function automatic logic valid_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // BCD minus one; a zero nibble becomes 9 and borrows from the next digit.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next-state: load > start > pause > gameTick; flags derived from next state.
  always_comb begin
    state_d      = state_q;
    digits_d     = digits_q;
    expired_d    = 1'b0;
    load_error_d = 1'b0;

    if (bus.load) begin
      if (valid_bcd(bus.load_value)) begin
        digits_d = bus.load_value;
        state_d  = StIdle;
      end else begin
        load_error_d = 1'b1;
      end
    end else if (bus.start) begin
      unique case (state_q)
        StIdle:   if (digits_q != 16'h0000) state_d = StRun;
        StPaused: state_d = StRun;
        StRun: begin
          // start is a no-op in RUN, so a coincident tick still counts.
          if (bus.gameTick && digits_q != 16'h0000) begin
            digits_d = bcd_dec(digits_q);
            if (digits_q == 16'h0001) begin
              state_d   = StExpired;
              expired_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (bus.pause) begin
      unique case (state_q)
        StRun:    state_d = StPaused;
        StPaused: state_d = StRun;
        default:  ;
      endcase
    end else if (bus.gameTick) begin
      if (state_q == StRun && digits_q != 16'h0000) begin
        digits_d = bcd_dec(digits_q);
        if (digits_q == 16'h0001) begin
          state_d   = StExpired;
          expired_d = 1'b1;
        end
      end
    end

    running_d = (state_d == StRun);
    timeup_d  = (state_d == StExpired);
    warning_d = ((state_d == StRun) || (state_d == StPaused)) &&
                (digits_d != 16'h0000) && (digits_d <= WARN_THRESHOLD);
  end

  // State and registered flags; reset drops any pending expired pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      digits_q     <= START_VALUE;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      timeup_q     <= 1'b0;
      warning_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
      timeup_q     <= timeup_d;
      warning_q    <= warning_d;
      load_error_q <= load_error_d;
    end
  end

  logic blank3, blank2, blank1;

  // Seven-segment decode with leading-zero blanking on the upper three digits.
  always_comb begin
    blank3   = BLANK_LZ && (digits_q[15:12] == 4'd0);
    blank2   = blank3 && (digits_q[11:8] == 4'd0);
    blank1   = blank2 && (digits_q[7:4] == 4'd0);
    bus.HEX3 = blank3 ? 7'b1111111 : seg7(digits_q[15:12]);
    bus.HEX2 = blank2 ? 7'b1111111 : seg7(digits_q[11:8]);
    bus.HEX1 = blank1 ? 7'b1111111 : seg7(digits_q[7:4]);
    bus.HEX0 = seg7(digits_q[3:0]);
  end

  assign bus.digits     = digits_q;
  assign bus.running    = running_q;
  assign bus.expired    = expired_q;
  assign bus.timeUp     = timeup_q;
  assign bus.warning    = warning_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the BCD round timer with hand-computed expectations.
module tb_bcd_countdown_timer;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(
    .START_VALUE   (16'h0060),
    .WARN_THRESHOLD(16'h0010),
    .BLANK_LZ      (1'b1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] Seg8     = 7'b0000000;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.load       = 1'b0;
    bus.load_value = 16'h0000;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.gameTick   = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load       = 1'b1;
    bus.load_value = v;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    bus.gameTick = 1'b1;
    step(n);
    bus.gameTick = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    idle_inputs();
    #12;
    reset_n = 1'b1;
    step(1);

    // Reset state and display.
    check("rst_digits", bus.digits, 16'h0060);
    check("rst_running", {15'd0, bus.running}, 16'd0);
    check("rst_expired", {15'd0, bus.expired}, 16'd0);
    check("rst_timeup", {15'd0, bus.timeUp}, 16'd0);
    check("rst_warning", {15'd0, bus.warning}, 16'd0);
    check("rst_load_error", {15'd0, bus.load_error}, 16'd0);
    check("rst_hex3", {9'd0, bus.HEX3}, {9'd0, SegBlank});
    check("rst_hex2", {9'd0, bus.HEX2}, {9'd0, SegBlank});
    check("rst_hex1", {9'd0, bus.HEX1}, {9'd0, Seg6});
    check("rst_hex0", {9'd0, bus.HEX0}, {9'd0, Seg0});

    // Ticks in IDLE are ignored.
    do_ticks(5);
    check("idle_ticks", bus.digits, 16'h0060);

    // Borrow ripple through two digits.
    do_load(16'h0100);
    do_start();
    check("run_running", {15'd0, bus.running}, 16'd1);
    do_ticks(1);
    check("ripple_0099", bus.digits, 16'h0099);
    check("ripple_hex2", {9'd0, bus.HEX2}, {9'd0, SegBlank});
    check("ripple_hex1", {9'd0, bus.HEX1}, {9'd0, Seg9});
    do_ticks(1);
    check("dec_0098", bus.digits, 16'h0098);
    check("dec_hex0", {9'd0, bus.HEX0}, {9'd0, Seg8});

    // Expiry path.
    do_load(16'h0002);
    do_start();
    do_ticks(1);
    check("exp_0001", bus.digits, 16'h0001);
    check("exp_warn_0001", {15'd0, bus.warning}, 16'd1);
    check("exp_pre_expired", {15'd0, bus.expired}, 16'd0);
    do_ticks(1);
    check("exp_digits", bus.digits, 16'h0000);
    check("exp_pulse", {15'd0, bus.expired}, 16'd1);
    check("exp_timeup", {15'd0, bus.timeUp}, 16'd1);
    check("exp_running", {15'd0, bus.running}, 16'd0);
    check("exp_warning", {15'd0, bus.warning}, 16'd0);
    check("exp_hex1", {9'd0, bus.HEX1}, {9'd0, SegBlank});
    check("exp_hex0", {9'd0, bus.HEX0}, {9'd0, Seg0});
    step(1);
    check("exp_pulse_gone", {15'd0, bus.expired}, 16'd0);
    check("exp_timeup_held", {15'd0, bus.timeUp}, 16'd1);
    bus.start    = 1'b1;
    bus.gameTick = 1'b1;
    step(2);
    idle_inputs();
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    check("exp_stuck_digits", bus.digits, 16'h0000);
    check("exp_stuck_running", {15'd0, bus.running}, 16'd0);
    check("exp_stuck_timeup", {15'd0, bus.timeUp}, 16'd1);

    // Pause wins over coincident tick; resume does not decrement.
    do_load(16'h0015);
    check("load_clears_timeup", {15'd0, bus.timeUp}, 16'd0);
    do_start();
    bus.pause    = 1'b1;
    bus.gameTick = 1'b1;
    step(1);
    idle_inputs();
    check("pause_digits", bus.digits, 16'h0015);
    check("pause_running", {15'd0, bus.running}, 16'd0);
    check("pause_warning", {15'd0, bus.warning}, 16'd0);
    do_ticks(3);
    check("pause_ticks", bus.digits, 16'h0015);
    do_start();
    check("resume_running", {15'd0, bus.running}, 16'd1);
    check("resume_no_dec", bus.digits, 16'h0015);
    do_ticks(1);
    check("resume_dec", bus.digits, 16'h0014);

    // Warning at threshold; invalid load; load beats start.
    do_load(16'h0011);
    do_start();
    do_ticks(1);
    check("warn_digits", bus.digits, 16'h0010);
    check("warn_on", {15'd0, bus.warning}, 16'd1);
    bus.gameTick = 1'b1;
    do_load(16'h00A5);
    bus.gameTick = 1'b0;
    check("bad_load_error", {15'd0, bus.load_error}, 16'd1);
    check("bad_load_digits", bus.digits, 16'h0010);
    check("bad_load_running", {15'd0, bus.running}, 16'd1);
    step(1);
    check("bad_load_pulse_gone", {15'd0, bus.load_error}, 16'd0);
    bus.start = 1'b1;
    do_load(16'h0042);
    bus.start = 1'b0;
    check("load_start_digits", bus.digits, 16'h0042);
    check("load_start_running", {15'd0, bus.running}, 16'd0);
    check("load_start_warning", {15'd0, bus.warning}, 16'd0);

    // Start at 0000 in IDLE is ignored.
    do_load(16'h0000);
    do_start();
    check("zero_start_running", {15'd0, bus.running}, 16'd0);

    // Asynchronous reset mid-run.
    do_load(16'h0037);
    do_start();
    check("mid_running", {15'd0, bus.running}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_digits", bus.digits, 16'h0060);
    check("async_running", {15'd0, bus.running}, 16'd0);
    check("async_warning", {15'd0, bus.warning}, 16'd0);
    step(1);
    reset_n = 1'b1;
    step(1);
    check("post_rst_digits", bus.digits, 16'h0060);
    check("post_rst_flags",
          {11'd0, bus.running, bus.expired, bus.timeUp, bus.warning, bus.load_error},
          16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
